// File: rtl/instr_fetch_pkg.sv
// Shared fetch definitions: FSM state encodings, default widths, reset address, address adder.
package instr_fetch_pkg;

    localparam int          ADDR_W_DEF = 16;
    localparam int          DATA_W_DEF = 16;
    localparam logic [15:0] RESET_ADDR = 16'h0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_HOLD  = 2'd3
    } fetch_state_e;

    // 16-bit adder; the carry out is dropped so addresses wrap modulo 2^16
    function automatic logic [15:0] add16(input logic [15:0] a, input logic [15:0] b);
        return a + b;
    endfunction

endpackage

// File: rtl/instr_fetch_buffer.sv
// One-entry prefetch buffer (address, data, valid); invalidate wins over load.
module instr_fetch_buffer
    import instr_fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              load_i,
    input  logic              inval_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [ADDR_W-1:0] addr_o,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o
);

    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              valid_q;

    // Buffer entry register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            addr_q  <= ADDR_W'(RESET_ADDR);
            data_q  <= {DATA_W{1'b0}};
            valid_q <= 1'b0;
        end else if (inval_i) begin
            valid_q <= 1'b0;
        end else if (load_i) begin
            addr_q  <= addr_i;
            data_q  <= data_i;
            valid_q <= 1'b1;
        end else begin
            valid_q <= valid_q;
        end
    end

    assign addr_o  = addr_q;
    assign data_o  = data_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: PC handshake -> ROM req/ack -> decode valid/ready, with jump flush.
// Define FETCH_PREFETCH_EN to add a one-entry sequential prefetch buffer.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic [ADDR_W-1:0] pc_i,
    input  logic              pc_valid_i,
    output logic              pc_ready_o,
    input  logic              flush_i,
    output logic              rom_req_o,
    output logic [ADDR_W-1:0] rom_addr_o,
    input  logic              rom_ack_i,
    input  logic [DATA_W-1:0] rom_data_i,
    output logic [DATA_W-1:0] instr_o,
    output logic [ADDR_W-1:0] instr_addr_o,
    output logic              instr_valid_o,
    input  logic              instr_ready_i
);

    fetch_state_e      state_q, state_d;
    logic              rom_req_q, rom_req_d;
    logic [ADDR_W-1:0] rom_addr_q, rom_addr_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [ADDR_W-1:0] instr_addr_q, instr_addr_d;
    logic              instr_valid_q, instr_valid_d;
    logic              pc_xfer_s;

`ifdef FETCH_PREFETCH_EN
    logic              pf_busy_q, pf_busy_d;
    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] pend_addr_q, pend_addr_d;
    logic              buf_load_s, buf_inval_s, buf_valid_s, buf_hit_s;
    logic [ADDR_W-1:0] buf_addr_s;
    logic [DATA_W-1:0] buf_data_s;

    instr_fetch_buffer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_buffer (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load_i  (buf_load_s),
        .inval_i (buf_inval_s),
        .addr_i  (rom_addr_q),
        .data_i  (rom_data_i),
        .addr_o  (buf_addr_s),
        .data_o  (buf_data_s),
        .valid_o (buf_valid_s)
    );

    assign buf_hit_s   = buf_valid_s && (buf_addr_s == pc_i);
    assign buf_inval_s = flush_i || pc_xfer_s;
`endif

    // A jump always blocks acceptance of a new pc in the same cycle
    assign pc_ready_o = !flush_i && ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && instr_ready_i));
    assign pc_xfer_s  = pc_valid_i && pc_ready_o;

    // Next-state and registered-output logic
    always_comb begin
        state_d       = state_q;
        rom_req_d     = rom_req_q;
        rom_addr_d    = rom_addr_q;
        instr_d       = instr_q;
        instr_addr_d  = instr_addr_q;
        instr_valid_d = instr_valid_q;
`ifdef FETCH_PREFETCH_EN
        pf_busy_d     = pf_busy_q;
        pend_d        = pend_q;
        pend_addr_d   = pend_addr_q;
        buf_load_s    = 1'b0;
`endif
        case (state_q)
            ST_IDLE, ST_HOLD: begin
                if ((state_q == ST_HOLD) && (flush_i || instr_ready_i)) begin
                    state_d       = ST_IDLE;
                    instr_valid_d = 1'b0;
                end else begin
                    state_d = state_q;
                end
`ifdef FETCH_PREFETCH_EN
                // A prefetch completes, is forced to finish through DRAIN by a jump, or starts here
                if (pf_busy_q && rom_ack_i) begin
                    pf_busy_d  = 1'b0;
                    rom_req_d  = 1'b0;
                    buf_load_s = !buf_inval_s;
                end else if (pf_busy_q && flush_i) begin
                    pf_busy_d = 1'b0;
                    state_d   = ST_DRAIN;
                end else if ((state_q == ST_HOLD) && !flush_i && !pc_xfer_s && !rom_req_q && !buf_valid_s) begin
                    pf_busy_d  = 1'b1;
                    rom_req_d  = 1'b1;
                    rom_addr_d = ADDR_W'(add16(16'(instr_addr_q), 16'h0001));
                end else begin
                    pf_busy_d = pf_busy_q;
                end
`endif
                if (pc_xfer_s) begin
`ifdef FETCH_PREFETCH_EN
                    if (buf_hit_s) begin
                        state_d       = ST_HOLD;
                        instr_d       = buf_data_s;
                        instr_addr_d  = buf_addr_s;
                        instr_valid_d = 1'b1;
                    end else if (pf_busy_q && (pc_i == rom_addr_q)) begin
                        // The in-flight prefetch is the wanted address: adopt it as the demand read
                        pf_busy_d = 1'b0;
                        if (rom_ack_i) begin
                            state_d       = ST_HOLD;
                            instr_d       = rom_data_i;
                            instr_addr_d  = rom_addr_q;
                            instr_valid_d = 1'b1;
                        end else begin
                            state_d = ST_REQ;
                        end
                    end else if (pf_busy_q && !rom_ack_i) begin
                        pf_busy_d   = 1'b0;
                        state_d     = ST_DRAIN;
                        pend_d      = 1'b1;
                        pend_addr_d = pc_i;
                    end else begin
                        state_d    = ST_REQ;
                        rom_req_d  = 1'b1;
                        rom_addr_d = pc_i;
                    end
`else
                    state_d    = ST_REQ;
                    rom_req_d  = 1'b1;
                    rom_addr_d = pc_i;
`endif
                end else begin
                    instr_d = instr_q;
                end
            end
            ST_REQ: begin
                if (rom_ack_i) begin
                    rom_req_d = 1'b0;
                    if (flush_i) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d       = ST_HOLD;
                        instr_d       = rom_data_i;
                        instr_addr_d  = rom_addr_q;
                        instr_valid_d = 1'b1;
                    end
                end else if (flush_i) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (rom_ack_i) begin
`ifdef FETCH_PREFETCH_EN
                    if (pend_q && !flush_i) begin
                        state_d    = ST_REQ;
                        rom_addr_d = pend_addr_q;
                    end else begin
                        state_d   = ST_IDLE;
                        rom_req_d = 1'b0;
                    end
                    pend_d = 1'b0;
`else
                    state_d   = ST_IDLE;
                    rom_req_d = 1'b0;
`endif
                end else begin
`ifdef FETCH_PREFETCH_EN
                    pend_d = pend_q && !flush_i;
`endif
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d       = ST_IDLE;
                rom_req_d     = 1'b0;
                instr_valid_d = 1'b0;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Registered ROM and decode-side outputs
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rom_req_q     <= 1'b0;
            rom_addr_q    <= ADDR_W'(RESET_ADDR);
            instr_q       <= {DATA_W{1'b0}};
            instr_addr_q  <= ADDR_W'(RESET_ADDR);
            instr_valid_q <= 1'b0;
        end else begin
            rom_req_q     <= rom_req_d;
            rom_addr_q    <= rom_addr_d;
            instr_q       <= instr_d;
            instr_addr_q  <= instr_addr_d;
            instr_valid_q <= instr_valid_d;
        end
    end

`ifdef FETCH_PREFETCH_EN
    // Prefetch tracking and the address parked while a stale prefetch drains
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            pf_busy_q   <= 1'b0;
            pend_q      <= 1'b0;
            pend_addr_q <= ADDR_W'(RESET_ADDR);
        end else begin
            pf_busy_q   <= pf_busy_d;
            pend_q      <= pend_d;
            pend_addr_q <= pend_addr_d;
        end
    end
`endif

    assign rom_req_o     = rom_req_q;
    assign rom_addr_o    = rom_addr_q;
    assign instr_o       = instr_q;
    assign instr_addr_o  = instr_addr_q;
    assign instr_valid_o = instr_valid_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Self-checking bench for instr_fetch: behavioural ROM with variable latency plus an
// address/data scoreboard checked whenever decode consumes an instruction.
module tb_instr_fetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc;
    logic        pc_valid;
    logic        pc_ready;
    logic        flush;
    logic        rom_req;
    logic [15:0] rom_addr;
    logic        rom_ack;
    logic [15:0] rom_data;
    logic [15:0] instr;
    logic [15:0] instr_addr;
    logic        instr_valid;
    logic        instr_ready;

    int          tests_run = 0;
    int          tests_failed = 0;
    int          rom_lat = 0;
    int          rom_wait = 0;
    logic [31:0] exp_q[$];
    logic [31:0] sb_exp;

    always #5 clk = ~clk;

    instr_fetch dut (
        .clk_i         (clk),
        .reset_i       (reset),
        .pc_i          (pc),
        .pc_valid_i    (pc_valid),
        .pc_ready_o    (pc_ready),
        .flush_i       (flush),
        .rom_req_o     (rom_req),
        .rom_addr_o    (rom_addr),
        .rom_ack_i     (rom_ack),
        .rom_data_i    (rom_data),
        .instr_o       (instr),
        .instr_addr_o  (instr_addr),
        .instr_valid_o (instr_valid),
        .instr_ready_i (instr_ready)
    );

    function automatic logic [15:0] rom_word(input logic [15:0] a);
        case (a)
            16'h0010: return 16'hE308;
            16'h0020: return 16'h1234;
            default:  return a ^ 16'h5A5A;
        endcase
    endfunction

    // ROM model: acks once the request has been up for rom_lat cycles
    assign rom_ack  = rom_req && (rom_wait >= rom_lat);
    assign rom_data = rom_ack ? rom_word(rom_addr) : 16'hDEAD;

    always @(posedge clk) begin
        if (reset || !rom_req || rom_ack) rom_wait <= 0;
        else rom_wait <= rom_wait + 1;
    end

    // Scoreboard: every consumed instruction must match the oldest accepted pc
    always @(negedge clk) begin
        if (!reset && instr_valid && instr_ready) begin
            tests_run++;
            if (exp_q.size() == 0) begin
                tests_failed++;
                $display("FAIL sb_extra: got addr=%h data=%h, expected no instruction", instr_addr, instr);
            end else begin
                sb_exp = exp_q.pop_front();
                if ({instr_addr, instr} !== sb_exp) begin
                    tests_failed++;
                    $display("FAIL sb_data: got addr=%h data=%h, expected addr=%h data=%h",
                             instr_addr, instr, sb_exp[31:16], sb_exp[15:0]);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [15:0] a);
        exp_q.push_back({a, rom_word(a)});
    endtask

    task automatic test_reset();
        reset = 1'b1; pc = 16'h0000; pc_valid = 1'b0; flush = 1'b0; instr_ready = 1'b0; rom_lat = 0;
        tick(); tick();
        reset = 1'b0;
        #1;
        tests_run++;
        if ({rom_req, rom_addr, instr, instr_addr, instr_valid} !== 50'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got req=%b addr=%h instr=%h iaddr=%h ivalid=%b, expected all 0",
                     rom_req, rom_addr, instr, instr_addr, instr_valid);
        end
        tests_run++;
        if (pc_ready !== 1'b1) begin tests_failed++; $display("FAIL reset_pc_ready: got %b expected 1", pc_ready); end
    endtask

    task automatic test_basic_fetch();
        pc = 16'h0010; pc_valid = 1'b1; instr_ready = 1'b0;
        #1;
        tests_run++;
        if (pc_ready !== 1'b1) begin tests_failed++; $display("FAIL basic_pc_ready: got %b expected 1", pc_ready); end
        push(16'h0010);
        tick();
        pc_valid = 1'b0;
        tests_run++;
        if ({rom_req, rom_addr} !== {1'b1, 16'h0010}) begin
            tests_failed++; $display("FAIL basic_req: got req=%b addr=%h expected req=1 addr=0010", rom_req, rom_addr);
        end
        tests_run++;
        if (instr_valid !== 1'b0) begin tests_failed++; $display("FAIL basic_early_valid: got %b expected 0", instr_valid); end
        tick();
        tests_run++;
        if ({instr_valid, instr_addr, instr} !== {1'b1, 16'h0010, 16'hE308}) begin
            tests_failed++;
            $display("FAIL basic_instr: got v=%b addr=%h data=%h expected v=1 addr=0010 data=e308", instr_valid, instr_addr, instr);
        end
    endtask

    task automatic test_stall();
        pc = 16'h0011; pc_valid = 1'b1; instr_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            tests_run++;
            if (pc_ready !== 1'b0) begin tests_failed++; $display("FAIL stall_pc_ready: got %b expected 0", pc_ready); end
            tests_run++;
            if ({instr_valid, instr_addr, instr} !== {1'b1, 16'h0010, 16'hE308}) begin
                tests_failed++;
                $display("FAIL stall_hold: got v=%b addr=%h data=%h expected v=1 addr=0010 data=e308", instr_valid, instr_addr, instr);
            end
            tick();
        end
        instr_ready = 1'b1;
        #1;
        tests_run++;
        if (pc_ready !== 1'b1) begin tests_failed++; $display("FAIL stall_release_ready: got %b expected 1", pc_ready); end
        push(16'h0011);
        tick();
        pc_valid = 1'b0;
`ifdef FETCH_PREFETCH_EN
        tests_run++;
        if ({instr_valid, instr_addr} !== {1'b1, 16'h0011}) begin
            tests_failed++; $display("FAIL b2b_hit: got v=%b addr=%h expected v=1 addr=0011", instr_valid, instr_addr);
        end
`else
        tests_run++;
        if ({rom_req, rom_addr, instr_valid} !== {1'b1, 16'h0011, 1'b0}) begin
            tests_failed++;
            $display("FAIL b2b_req: got req=%b addr=%h v=%b expected req=1 addr=0011 v=0", rom_req, rom_addr, instr_valid);
        end
`endif
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        tests_run++;
        if (exp_q.size() != 0) begin tests_failed++; $display("FAIL stall_drain: %0d pending expected 0", exp_q.size()); end
        tick(); tick();
    endtask

    task automatic test_flush_req();
        logic acked;
        rom_lat = 3; instr_ready = 1'b1; pc = 16'h0020; pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0;
        tests_run++;
        if (rom_req !== 1'b1) begin tests_failed++; $display("FAIL flush_req_start: got %b expected 1", rom_req); end
        flush = 1'b1;
        #1;
        tests_run++;
        if (pc_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_pc_ready: got %b expected 0", pc_ready); end
        tick();
        flush = 1'b0;
        acked = 1'b0;
        for (int i = 0; i < 10 && !acked; i++) begin
            tests_run++;
            if ({rom_req, rom_addr, instr_valid} !== {1'b1, 16'h0020, 1'b0}) begin
                tests_failed++;
                $display("FAIL flush_drain: got req=%b addr=%h v=%b expected req=1 addr=0020 v=0", rom_req, rom_addr, instr_valid);
            end
            acked = rom_ack;
            tick();
        end
        tests_run++;
        if (acked !== 1'b1) begin tests_failed++; $display("FAIL flush_ack_timeout: got ack=%b expected 1", acked); end
        tests_run++;
        if ({rom_req, instr_valid, pc_ready} !== 3'b001) begin
            tests_failed++;
            $display("FAIL flush_after_ack: got req=%b v=%b rdy=%b expected req=0 v=0 rdy=1", rom_req, instr_valid, pc_ready);
        end
        rom_lat = 0;
    endtask

    task automatic test_flush_idle();
        flush = 1'b1; pc = 16'h0040; pc_valid = 1'b1;
        #1;
        tests_run++;
        if (pc_ready !== 1'b0) begin tests_failed++; $display("FAIL flush_idle_ready: got %b expected 0", pc_ready); end
        tick();
        flush = 1'b0; pc_valid = 1'b0;
        #1;
        tests_run++;
        if ({rom_req, pc_ready} !== 2'b01) begin
            tests_failed++; $display("FAIL flush_idle_noxfer: got req=%b rdy=%b expected req=0 rdy=1", rom_req, pc_ready);
        end
    endtask

    task automatic test_reset_mid_req();
        rom_lat = 3; pc = 16'h0050; pc_valid = 1'b1;
        tick();
        pc_valid = 1'b0;
        tests_run++;
        if (rom_req !== 1'b1) begin tests_failed++; $display("FAIL rst_req_start: got %b expected 1", rom_req); end
        reset = 1'b1;
        tick();
        tests_run++;
        if ({rom_req, rom_addr, instr, instr_addr, instr_valid} !== 50'd0) begin
            tests_failed++;
            $display("FAIL rst_mid_req: got req=%b addr=%h instr=%h iaddr=%h v=%b expected all 0",
                     rom_req, rom_addr, instr, instr_addr, instr_valid);
        end
        reset = 1'b0;
        rom_lat = 0;
        #1;
        tests_run++;
        if (pc_ready !== 1'b1) begin tests_failed++; $display("FAIL rst_pc_ready: got %b expected 1", pc_ready); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a;
        int sent;
        a = 16'hFFFC; sent = 0;
        for (int cyc = 0; cyc < 80 && sent < 8; cyc++) begin
            rom_lat     = $urandom_range(0, 2);
            instr_ready = ($urandom_range(0, 3) != 0);
            pc = a; pc_valid = 1'b1;
            #1;
            if (pc_ready) begin
                push(a);
                a = a + 16'h0001;
                sent++;
            end
            tick();
        end
        pc_valid = 1'b0; instr_ready = 1'b1;
        for (int i = 0; i < 30 && exp_q.size() != 0; i++) tick();
        tests_run++;
        if (sent != 8) begin tests_failed++; $display("FAIL b2b_accepted: got %0d expected 8", sent); end
        tests_run++;
        if (exp_q.size() != 0) begin tests_failed++; $display("FAIL b2b_drain: %0d pending expected 0", exp_q.size()); end
        rom_lat = 0;
        tick(); tick();
    endtask

`ifdef FETCH_PREFETCH_EN
    task automatic test_prefetch();
        logic [15:0] seq [3];
        seq[0] = 16'hFFFE; seq[1] = 16'hFFFF; seq[2] = 16'h0000;
        rom_lat = 1; instr_ready = 1'b0;
        flush = 1'b1; tick(); flush = 1'b0;
        pc = seq[0]; pc_valid = 1'b1;
        #1;
        push(seq[0]);
        tick();
        pc_valid = 1'b0;
        for (int i = 0; i < 10 && !instr_valid; i++) tick();
        for (int k = 1; k < 3; k++) begin
            repeat (4) tick();
            pc = seq[k]; pc_valid = 1'b1; instr_ready = 1'b1;
            #1;
            push(seq[k]);
            tick();
            pc_valid = 1'b0; instr_ready = 1'b0;
            tests_run++;
            if ({instr_valid, instr_addr, rom_req} !== {1'b1, seq[k], 1'b0}) begin
                tests_failed++;
                $display("FAIL pf_hit: got v=%b addr=%h req=%b expected v=1 addr=%h req=0", instr_valid, instr_addr, rom_req, seq[k]);
            end
        end
        repeat (4) tick();
        pc = 16'h0100; pc_valid = 1'b1; instr_ready = 1'b1;
        #1;
        push(16'h0100);
        tick();
        pc_valid = 1'b0;
        tests_run++;
        if ({instr_valid, rom_req, rom_addr} !== {1'b0, 1'b1, 16'h0100}) begin
            tests_failed++;
            $display("FAIL pf_miss: got v=%b req=%b addr=%h expected v=0 req=1 addr=0100", instr_valid, rom_req, rom_addr);
        end
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
        tests_run++;
        if (exp_q.size() != 0) begin tests_failed++; $display("FAIL pf_drain: %0d pending expected 0", exp_q.size()); end
        rom_lat = 0;
    endtask
`endif

    initial begin
        test_reset();
        test_basic_fetch();
        test_stall();
        test_flush_req();
        test_flush_idle();
        test_reset_mid_req();
        test_back_to_back();
`ifdef FETCH_PREFETCH_EN
        test_prefetch();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
